// File: rtl/popcount_accum_ctrl_pkg.sv
// ==========================================================================
// popcount_accum_ctrl_pkg : shared constants, state encoding, width rule
// Rev 1.0
// ==========================================================================
`default_nettype none

package popcount_accum_ctrl_pkg;

  localparam int unsigned C_DATA_W = 15;
  localparam int unsigned C_POP_W  = 4;

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_ACCUM = 2'd1;
  localparam logic [1:0] C_ST_DRAIN = 2'd2;
  localparam logic [1:0] C_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = C_ST_IDLE,
    ST_ACCUM = C_ST_ACCUM,
    ST_DRAIN = C_ST_DRAIN,
    ST_DONE  = C_ST_DONE
  } state_t;

  // Four extra bits hold (2^BEATS_W-1)*15 without overflow.
  function automatic int unsigned sum_w(input int unsigned beats_w);
    return beats_w + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/popcount_accum_ctrl_if.sv
// ==========================================================================
// popcount_accum_ctrl_if : job request, beat stream and result handshakes
// Rev 1.0
// ==========================================================================
`default_nettype none

interface popcount_accum_ctrl_if
  import popcount_accum_ctrl_pkg::*;
#(
  parameter int unsigned BEATS_W = 8,
  parameter int unsigned SUM_W   = sum_w(BEATS_W)
);

  logic                start;
  logic [BEATS_W-1:0]  beat_count;
  logic                in_valid;
  logic                in_ready;
  logic [C_DATA_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [SUM_W-1:0]    out_sum;
  logic                busy;

  modport master (
    output start, beat_count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, busy
  );

  modport slave (
    input  start, beat_count, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, busy
  );

endinterface

`default_nettype wire

// File: rtl/adder_15to4.sv
// ==========================================================================
// adder_15to4 : 15-input ones counter built from a full-adder compression tree
// Rev 1.0
// ==========================================================================
`default_nettype none

module adder_15to4 (
  input  wire logic [14:0] in_bits,
  output logic      [3:0]  pop
);

  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Level 1: five full adders, sums weight 1, carries weight 2.
  logic [1:0] w_l1_0, w_l1_1, w_l1_2, w_l1_3, w_l1_4;
  // Weight-1 reduction to the LSB.
  logic [1:0] w_w1_0, w_w1_1;
  // Weight-2 seven-input reduction.
  logic [1:0] w_w2_0, w_w2_1, w_w2_2;
  // Weight-4 three-input reduction gives bits 2 and 3.
  logic [1:0] w_w4_0;

  assign w_l1_0 = fa(in_bits[0],  in_bits[1],  in_bits[2]);
  assign w_l1_1 = fa(in_bits[3],  in_bits[4],  in_bits[5]);
  assign w_l1_2 = fa(in_bits[6],  in_bits[7],  in_bits[8]);
  assign w_l1_3 = fa(in_bits[9],  in_bits[10], in_bits[11]);
  assign w_l1_4 = fa(in_bits[12], in_bits[13], in_bits[14]);

  assign w_w1_0 = fa(w_l1_0[0], w_l1_1[0], w_l1_2[0]);
  assign w_w1_1 = fa(w_l1_3[0], w_l1_4[0], w_w1_0[0]);

  assign w_w2_0 = fa(w_l1_0[1], w_l1_1[1], w_l1_2[1]);
  assign w_w2_1 = fa(w_l1_3[1], w_l1_4[1], w_w1_0[1]);
  assign w_w2_2 = fa(w_w2_0[0], w_w2_1[0], w_w1_1[1]);

  assign w_w4_0 = fa(w_w2_0[1], w_w2_1[1], w_w2_2[1]);

  assign pop = {w_w4_0[1], w_w4_0[0], w_w2_2[0], w_w1_1[0]};

endmodule

`default_nettype wire

// File: rtl/popcount_accum_ctrl.sv
// ==========================================================================
// popcount_accum_ctrl : counts set bits over a job of 15-bit beats
// Rev 1.0
// ==========================================================================
`default_nettype none

module popcount_accum_ctrl
  import popcount_accum_ctrl_pkg::*;
#(
  parameter int unsigned BEATS_W = 8,
  parameter int unsigned SUM_W   = sum_w(BEATS_W)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  popcount_accum_ctrl_if.slave   bus
);

  state_t               state_q,     state_d;
  logic [BEATS_W-1:0]   remaining_q, remaining_d;
  logic [C_POP_W-1:0]   stage_q,     stage_d;
  logic                 stage_vld_q, stage_vld_d;
  logic [SUM_W-1:0]     acc_q,       acc_d;

  logic [C_POP_W-1:0]   pop;
  logic                 xfer;

  adder_15to4 u_adder_15to4 (
    .in_bits (bus.in_data),
    .pop     (pop)
  );

  assign xfer = (state_q == ST_ACCUM) && bus.in_valid;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    stage_vld_d = xfer;
    stage_d     = xfer ? pop : stage_q;
    acc_d       = stage_vld_q ? acc_q + {{(SUM_W-C_POP_W){1'b0}}, stage_q} : acc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          if (bus.beat_count != '0) begin
            state_d     = ST_ACCUM;
            remaining_d = bus.beat_count;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (xfer) begin
          remaining_d = remaining_q - BEATS_W'(1);
          if (remaining_q == BEATS_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      // The final beat's popcount lands in the accumulator during this cycle.
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      stage_q     <= stage_d;
      stage_vld_q <= stage_vld_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_sum   = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_popcount_accum_ctrl.sv
// ==========================================================================
// tb_popcount_accum_ctrl : directed vectors with hand-computed sums
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_popcount_accum_ctrl;

  localparam int unsigned BEATS_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  popcount_accum_ctrl_if #(.BEATS_W(BEATS_W)) ifc ();

  popcount_accum_ctrl #(.BEATS_W(BEATS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int unsigned bc);
    ifc.start      = 1'b1;
    ifc.beat_count = BEATS_W'(bc);
    tick();
    ifc.start      = 1'b0;
    ifc.beat_count = '0;
  endtask

  task automatic send(input logic [14:0] d, input bit bubble);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    tick();
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    if (bubble) tick();
  endtask

  // Called right after the last transfer edge: one DRAIN cycle, then DONE.
  task automatic expect_done(input string tag, input int unsigned exp_sum);
    chk({tag, "_drain_ov"}, ifc.out_valid, 0);
    chk({tag, "_drain_busy"}, ifc.busy, 1);
    tick();
    chk({tag, "_done_ov"}, ifc.out_valid, 1);
    chk({tag, "_sum"}, ifc.out_sum, exp_sum);
  endtask

  initial begin
    ifc.start      = 1'b0;
    ifc.beat_count = '0;
    ifc.in_valid   = 1'b0;
    ifc.in_data    = '0;
    ifc.out_ready  = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_ready", ifc.in_ready, 0);
    chk("rst_ov",    ifc.out_valid, 0);
    chk("rst_busy",  ifc.busy, 0);
    chk("rst_sum",   ifc.out_sum, 0);
    rst = 1'b0;
    tick();

    // Three full vectors, consumer always ready: 3*15 = 45.
    ifc.out_ready = 1'b1;
    start_job(3);
    chk("j1_ready", ifc.in_ready, 1);
    send(15'h7FFF, 0); send(15'h7FFF, 0); send(15'h7FFF, 0);
    expect_done("j1", 45);
    tick();
    chk("j1_idle", ifc.busy, 0);

    // Empty job goes straight to DONE with a zero result.
    start_job(0);
    chk("j0_ov",    ifc.out_valid, 1);
    chk("j0_sum",   ifc.out_sum, 0);
    chk("j0_ready", ifc.in_ready, 0);
    tick();
    chk("j0_idle",  ifc.busy, 0);
    chk("j0_ready2", ifc.in_ready, 0);

    // Bubbles and back-pressure: 1 + 0 + 8 + 14 = 23.
    ifc.out_ready = 1'b0;
    start_job(4);
    send(15'h0001, 1); send(15'h0000, 1); send(15'h5555, 1); send(15'h7FFE, 0);
    expect_done("j2", 23);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("j2_hold_ov",  ifc.out_valid, 1);
      chk("j2_hold_sum", ifc.out_sum, 23);
    end
    ifc.out_ready = 1'b1;
    tick();
    chk("j2_idle", ifc.busy, 0);
    chk("j2_ov_low", ifc.out_valid, 0);

    // Largest job: 255*15 = 3825 must not wrap.
    start_job(255);
    for (int i = 0; i < 255; i++) send(15'h7FFF, 0);
    expect_done("j3", 3825);
    tick();

    // Reset in the middle of a five-beat job, then a fresh one-beat job.
    ifc.out_ready = 1'b0;
    start_job(5);
    send(15'h7FFF, 0); send(15'h7FFF, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("j4_rst_busy",  ifc.busy, 0);
    chk("j4_rst_ready", ifc.in_ready, 0);
    chk("j4_rst_ov",    ifc.out_valid, 0);
    chk("j4_rst_sum",   ifc.out_sum, 0);
    tick();
    chk("j4_no_ov", ifc.out_valid, 0);
    start_job(1);
    send(15'h000F, 0);
    expect_done("j5", 4);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;

    // Disturbances: in_valid in IDLE, start during ACCUM and on the DONE exit.
    ifc.in_valid = 1'b1;
    ifc.in_data  = 15'h7FFF;
    tick(); tick();
    chk("j6_idle_busy", ifc.busy, 0);
    ifc.in_valid = 1'b0;
    start_job(2);
    ifc.start      = 1'b1;
    ifc.beat_count = 8'd7;
    send(15'h0003, 0);
    ifc.start = 1'b0;
    send(15'h0007, 0);
    expect_done("j6", 5);
    ifc.start = 1'b1;
    tick();
    chk("j6_done_start_ov",  ifc.out_valid, 1);
    chk("j6_done_start_sum", ifc.out_sum, 5);
    ifc.out_ready = 1'b1;
    tick();
    chk("j6_exit_busy", ifc.busy, 0);
    ifc.start     = 1'b0;
    ifc.out_ready = 1'b0;
    tick();
    chk("j6_still_idle", ifc.busy, 0);
    chk("j6_no_ready",   ifc.in_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/popcount_accum_ctrl.md
POPCOUNT_ACCUM_CTRL -- requirements
Module: popcount_accum_ctrl

Interface
REQ-001 Parameter BEATS_W, default 8; width of the beat-count field (max 2^BEATS_W-1 vectors per job).
REQ-002 Parameter SUM_W, default BEATS_W+4; width of the accumulated result, fixed at BEATS_W+4.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  job request, sampled only in IDLE.
REQ-006 beat_count  input  BEATS_W  number of 15-bit vectors in the job, captured with start.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  controller accepts in_data this cycle.
REQ-009 in_data  input  15  vector whose set bits are counted.
REQ-010 out_valid  output  1  out_sum holds the final job result.
REQ-011 out_ready  input  1  consumer accepts out_sum.
REQ-012 out_sum  output  SUM_W  total set bits over all job vectors.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, ACCUM, DRAIN, DONE.
REQ-015 IDLE: start=1 with beat_count>0 -> ACCUM next cycle; remaining counter loads beat_count, accumulator clears to 0.
REQ-016 IDLE: start=1 with beat_count=0 -> DONE next cycle, accumulator cleared to 0 (out_sum=0).
REQ-017 start while not in IDLE is ignored; beat_count is ignored except when start is accepted.
REQ-018 in_ready = 1 only in ACCUM; a beat transfers when in_valid & in_ready in the same cycle.
REQ-019 in_data with in_valid outside ACCUM is ignored and not counted.
REQ-020 Each transferred beat's 4-bit popcount (0..15) is registered in a stage register with a valid flag at the transfer edge.
REQ-021 A valid stage register is zero-extended to SUM_W and added into the accumulator on the following edge (1-cycle pipeline).
REQ-022 Remaining counter decrements by 1 per transferred beat; on the transfer that brings it to 0 the FSM goes to DRAIN.
REQ-023 DRAIN lasts exactly one cycle (the final stage-register add), then DONE.
REQ-024 Latency: out_valid rises 2 cycles after the clock edge of the last beat transfer.
REQ-025 DONE: out_valid=1, out_sum stable until out_valid & out_ready; then IDLE next cycle.
REQ-026 out_valid & out_ready with start=1 in the same cycle: start is not accepted (FSM not yet in IDLE).
REQ-027 in_valid gaps (bubbles) in ACCUM are legal; stage valid flag is 0 and the accumulator holds.
REQ-028 Accumulator never overflows: max result (2^BEATS_W-1)*15 < 2^SUM_W; no saturation logic.
REQ-029 out_sum is driven from the accumulator register in all states; its value is only meaningful while out_valid=1.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, in_ready=0, out_valid=0, busy=0, out_sum=0, stage valid=0, remaining counter=0, from any state.
REQ-031 Reset mid-job (ACCUM or DRAIN) discards all partial results; no out_valid for the aborted job.
REQ-032 rst has priority over start and all handshakes in the same cycle.

Structure
REQ-033 State encoding localparams (IDLE, ACCUM, DRAIN, DONE) and the SUM_W = BEATS_W+4 rule reside in the shared accelerator constants include.
REQ-034 Popcount is produced by exactly one instance of the existing adder_15to4 compression sub-module; no behavioural popcount in this block.
REQ-035 The stage register, accumulator, remaining counter and FSM are all in this module; there are no other sub-modules.

Verification
REQ-036 start, beat_count=3, in_data 7FFF,7FFF,7FFF back-to-back, out_ready=1 -> out_valid 2 cycles after 3rd transfer, out_sum=45.
REQ-037 start, beat_count=0 -> DONE next cycle, out_valid=1, out_sum=0, in_ready never asserted.
REQ-038 beat_count=4, data 0001,0000,5555,7FFE with 1-cycle in_valid bubbles, out_ready held 0 for 5 cycles -> out_sum=23 held stable, then IDLE one cycle after out_ready=1.
REQ-039 beat_count=255, all 7FFF -> out_sum=3825, no wrap.
REQ-040 rst asserted in ACCUM after 2 of 5 beats -> next cycle IDLE, all outputs 0; a new job beat_count=1, data 000F -> out_sum=4.
REQ-041 start pulsed during ACCUM and DONE; in_valid driven during IDLE -> ignored, result equals the undisturbed job's sum.
